// File: rtl/seg7_pkg.sv
// Shared types, constants and segment code table for the 7-segment display blocks.
package seg7_pkg;

  localparam int SLOT_TICKS = 16;

  typedef enum logic [1:0] {
    GUARD,
    DRIVE,
    DARK
  } scan_state_t;

  // Returns {A,B,C,D,E,F,G} for a hex digit.
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    logic [6:0] segs;
    case (hex)
      4'h0:    segs = 7'b1111110;
      4'h1:    segs = 7'b0110000;
      4'h2:    segs = 7'b1101101;
      4'h3:    segs = 7'b1111001;
      4'h4:    segs = 7'b0110011;
      4'h5:    segs = 7'b1011011;
      4'h6:    segs = 7'b1011111;
      4'h7:    segs = 7'b1110000;
      4'h8:    segs = 7'b1111111;
      4'h9:    segs = 7'b1111011;
      4'hA:    segs = 7'b1110111;
      4'hB:    segs = 7'b0011111;
      4'hC:    segs = 7'b0001101;
      4'hD:    segs = 7'b0111101;
      4'hE:    segs = 7'b1001111;
      default: segs = 7'b1000111;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port, brightness/enable controls and display pin outputs of the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                  i_en;
  logic                  i_wr_en;
  logic [2:0]            i_wr_addr;
  logic [4:0]            i_wr_data;
  logic [3:0]            i_brightness;
  logic [7:0]            o_seg;
  logic [NUM_DIGITS-1:0] o_dig_en;
  logic                  o_frame_tick;

  modport master (
    output i_en,
    output i_wr_en,
    output i_wr_addr,
    output i_wr_data,
    output i_brightness,
    input  o_seg,
    input  o_dig_en,
    input  o_frame_tick
  );

  modport slave (
    input  i_en,
    input  i_wr_en,
    input  i_wr_addr,
    input  i_wr_data,
    input  i_brightness,
    output o_seg,
    output o_dig_en,
    output o_frame_tick
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex + decimal point to {A,B,C,D,E,F,G,DP} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {hex_to_seg7(i_hex), i_dp};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-cathode 7-segment scanner: one digit per 16-tick slot,
// a dark guard tick at slot start, then a PWM window set by the latched brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_CYC   = 1040
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W = $clog2(TICK_CYC);
  localparam int SLOT_W = $clog2(SLOT_TICKS);

  logic [TICK_W-1:0]     r_tickCnt;
  logic [SLOT_W-1:0]     r_slotTick;
  logic [IDX_W-1:0]      r_digIdx;
  logic                  r_started;
  logic [4:0]            r_regFile [NUM_DIGITS];
  logic [4:0]            r_entryShadow;
  logic [3:0]            r_brightShadow;
  scan_state_t           r_state;
  scan_state_t           w_nextState;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digEn;
  logic                  r_frameTick;

  logic                  w_tickStrobe;
  logic                  w_slotStart;
  logic                  w_lastDigit;
  logic [IDX_W-1:0]      w_nextIdx;
  logic                  w_wrValid;
  logic                  w_drive;
  logic [7:0]            w_decSeg;
  logic [7:0]            w_segNext;
  logic [NUM_DIGITS-1:0] w_digEnNext;
  logic                  w_frameNext;

  assign w_tickStrobe = (r_tickCnt == TICK_W'(TICK_CYC - 1));
  assign w_slotStart  = w_tickStrobe && (r_slotTick == SLOT_W'(SLOT_TICKS - 1));
  assign w_lastDigit  = (r_digIdx == IDX_W'(NUM_DIGITS - 1));
  assign w_wrValid    = bus.i_wr_en && (32'(bus.i_wr_addr) < NUM_DIGITS);

  // The slot that runs straight out of reset is a dark preamble, so the first real
  // slot start keeps the index at digit 0 instead of advancing it.
  assign w_nextIdx = (!r_started || w_lastDigit) ? '0 : r_digIdx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tickCnt  <= '0;
      r_slotTick <= '0;
      r_digIdx   <= '0;
      r_started  <= 1'b0;
    end else begin
      r_tickCnt <= w_tickStrobe ? '0 : r_tickCnt + TICK_W'(1);
      if (w_tickStrobe) begin
        r_slotTick <= r_slotTick + SLOT_W'(1);
      end
      if (w_slotStart) begin
        r_digIdx  <= w_nextIdx;
        r_started <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_regFile[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regFile[bus.i_wr_addr[IDX_W-1:0]] <= bus.i_wr_data;
    end
  end

  // Shadows read the register file before this edge's write lands, so a write on
  // the slot-start edge only shows up on the digit's next scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entryShadow  <= '0;
      r_brightShadow <= '0;
    end else if (w_slotStart) begin
      r_entryShadow  <= r_regFile[w_nextIdx];
      r_brightShadow <= bus.i_brightness;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GUARD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Transitions fire on the same edge the slot tick index moves, so r_state always
  // describes the current value of r_slotTick.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      GUARD: begin
        if (w_tickStrobe) begin
          w_nextState = (r_brightShadow != 4'd0) ? DRIVE : DARK;
        end
      end
      DRIVE: begin
        if (w_slotStart) begin
          w_nextState = GUARD;
        end else if (w_tickStrobe && (r_slotTick >= r_brightShadow)) begin
          w_nextState = DARK;
        end
      end
      DARK: begin
        if (w_slotStart) begin
          w_nextState = GUARD;
        end
      end
      default: w_nextState = GUARD;
    endcase
  end

  seg7_hex_decode u_hexDecode (
    .i_hex (r_entryShadow[3:0]),
    .i_dp  (r_entryShadow[4]),
    .o_seg (w_decSeg)
  );

  assign w_drive = (r_state == DRIVE) && bus.i_en;

  always_comb begin
    w_segNext   = '0;
    w_digEnNext = '0;
    if (w_drive) begin
      w_segNext   = w_decSeg;
      w_digEnNext = NUM_DIGITS'(1) << r_digIdx;
    end
  end

  assign w_frameNext = r_started && (r_tickCnt == '0) && (r_slotTick == '0) && (r_digIdx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg       <= '0;
      r_digEn     <= '0;
      r_frameTick <= 1'b0;
    end else begin
      r_seg       <= w_segNext;
      r_digEn     <= w_digEnNext;
      r_frameTick <= w_frameNext;
    end
  end

  assign bus.o_seg        = r_seg;
  assign bus.o_dig_en     = r_digEn;
  assign bus.o_frame_tick = r_frameTick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, TICK_CYC=4): a cycle-count
// reference model checks every clock, plus table-driven and hand-written corner cases.
module tb_seg7_scan_ctrl;

  localparam int NDIG = 4;
  localparam int TCYC = 4;
  localparam int SLOT = 16 * TCYC;
  localparam int FRAME = NDIG * SLOT;

  typedef struct {
    logic [2:0] addr;
    logic [4:0] data;
    logic [7:0] expSeg;
    logic [3:0] expDig;
  } scan_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  logic [6:0] segTab [16];
  logic [4:0] mdlRegs [NDIG];
  logic [4:0] mdlEntry;
  logic [3:0] mdlBright;
  int t;

  seg7_scan_ctrl_if #(.NUM_DIGITS(NDIG)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (NDIG),
    .TICK_CYC   (TCYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic en, input logic wrEn, input logic [2:0] addr,
                               input logic [4:0] data, input logic [3:0] bright);
    bus.i_en         = en;
    bus.i_wr_en      = wrEn;
    bus.i_wr_addr    = addr;
    bus.i_wr_data    = data;
    bus.i_brightness = bright;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eSeg, input logic [3:0] eDig,
                             input logic eFt);
    nCompared++;
    if (bus.o_seg !== eSeg || bus.o_dig_en !== eDig || bus.o_frame_tick !== eFt) begin
      nMismatched++;
      $display("[TB] FAIL %s: got seg=%h dig_en=%b frame_tick=%b, want seg=%h dig_en=%b frame_tick=%b",
               name, bus.o_seg, bus.o_dig_en, bus.o_frame_tick, eSeg, eDig, eFt);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic clearModel();
    t = 0;
    mdlEntry = '0;
    mdlBright = '0;
    for (int i = 0; i < NDIG; i++) mdlRegs[i] = '0;
  endtask

  // Expected outputs follow from the number of clocks since reset release alone:
  // slot = u/SLOT, slot tick = (u%SLOT)/TCYC, with slot 0 being a dark preamble.
  task automatic stepCycle();
    logic sEn, sWr;
    logic [2:0] sAddr;
    logic [4:0] sData;
    logic [3:0] sBr;
    int u, tk, slotNum;
    logic [7:0] eSeg;
    logic [3:0] eDig;
    logic eFt;
    @(posedge clk);
    sEn = bus.i_en;
    sWr = bus.i_wr_en;
    sAddr = bus.i_wr_addr;
    sData = bus.i_wr_data;
    sBr = bus.i_brightness;
    t++;
    u = t - 1;
    eSeg = 8'h00;
    eDig = 4'b0000;
    if (u >= SLOT) begin
      slotNum = u / SLOT;
      tk = (u % SLOT) / TCYC;
      if (sEn && tk >= 1 && tk <= int'(mdlBright)) begin
        eSeg = {segTab[mdlEntry[3:0]], mdlEntry[4]};
        eDig = 4'b0001 << ((slotNum - 1) % NDIG);
      end
    end
    eFt = (u >= SLOT) && ((u - SLOT) % FRAME == 0);
    if (t % SLOT == 0) begin
      mdlEntry = mdlRegs[((t / SLOT) - 1) % NDIG];
      mdlBright = sBr;
    end
    if (sWr && sAddr < 3'(NDIG)) mdlRegs[sAddr[1:0]] = sData;
    #1;
    checkOutput($sformatf("model cycle %0d", t), eSeg, eDig, eFt);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic waitFrameTick(input int budget, input string name);
    int waited;
    waited = 0;
    do begin
      stepCycle();
      waited++;
    end while (bus.o_frame_tick !== 1'b1 && waited < budget);
    if (bus.o_frame_tick !== 1'b1) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: got no frame_tick within %0d cycles, want a pulse", name, budget);
    end
  endtask

  task automatic countDigOn(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      stepCycle();
      if (bus.o_dig_en != 4'b0000) cnt++;
    end
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    scan_vec_t vecs [4];
    logic [7:0] frameSeg [4];
    int guardCnt, driveCnt, cnt, tFrame;

    vecs[0] = '{3'd0, 5'h01, 8'h60, 4'b0001};
    vecs[1] = '{3'd1, 5'h0A, 8'hEE, 4'b0010};
    vecs[2] = '{3'd2, 5'h15, 8'hB7, 4'b0100};
    vecs[3] = '{3'd3, 5'h0F, 8'h8E, 4'b1000};
    frameSeg[0] = 8'h60;
    frameSeg[1] = 8'hFE;
    frameSeg[2] = 8'hF2;
    frameSeg[3] = 8'h8E;

    segTab[0]  = 7'b1111110; segTab[1]  = 7'b0110000; segTab[2]  = 7'b1101101;
    segTab[3]  = 7'b1111001; segTab[4]  = 7'b0110011; segTab[5]  = 7'b1011011;
    segTab[6]  = 7'b1011111; segTab[7]  = 7'b1110000; segTab[8]  = 7'b1111111;
    segTab[9]  = 7'b1111011; segTab[10] = 7'b1110111; segTab[11] = 7'b0011111;
    segTab[12] = 7'b0001101; segTab[13] = 7'b0111101; segTab[14] = 7'b1001111;
    segTab[15] = 7'b1000111;
    clearModel();

    $display("[TB] reset and first frame");
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("outputs during reset", 8'h00, 4'b0000, 1'b0);
    releaseReset();

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, vecs[k].addr, vecs[k].data, 4'd15);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    waitFrameTick(200, "first frame_tick");
    checkValue("first frame_tick cycle after release", t, 65);

    $display("[TB] write and scan table");
    for (int k = 0; k < 4; k++) begin
      guardCnt = 0;
      driveCnt = 0;
      for (int j = 0; j < SLOT; j++) begin
        if (k != 0 || j != 0) stepCycle();
        if (j < TCYC) begin
          if (bus.o_seg == 8'h00 && bus.o_dig_en == 4'b0000) guardCnt++;
        end else begin
          if (bus.o_seg == vecs[k].expSeg && bus.o_dig_en == vecs[k].expDig) driveCnt++;
        end
      end
      checkValue($sformatf("slot %0d guard dark cycles", k), guardCnt, TCYC);
      checkValue($sformatf("slot %0d drive cycles", k), driveCnt, SLOT - TCYC);
    end

    $display("[TB] PWM");
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd3);
    waitFrameTick(300, "frame before pwm 3");
    runCycles(SLOT - 1);
    countDigOn(SLOT, cnt);
    checkValue("brightness 3 on-cycles per slot", cnt, 12);
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd0);
    waitFrameTick(300, "frame before pwm 0");
    countDigOn(FRAME, cnt);
    checkValue("brightness 0 on-cycles per frame", cnt, 0);

    $display("[TB] tearing");
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    waitFrameTick(300, "frame before tearing");
    runCycles(84);
    applyStimulus(1'b1, 1'b1, 3'd1, 5'h08, 4'd15);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    runCycles(10);
    checkOutput("tearing current slot keeps old code", 8'hEE, 4'b0010, 1'b0);
    waitFrameTick(300, "frame after tearing write");
    runCycles(84);
    checkOutput("tearing next frame shows new code", 8'hFE, 4'b0010, 1'b0);

    $display("[TB] same-cycle write and bounds");
    runCycles(42);
    applyStimulus(1'b1, 1'b1, 3'd2, 5'h03, 4'd15);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    runCycles(13);
    checkOutput("write on slot start missed", 8'hB7, 4'b0100, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd5, 5'h1F, 4'd15);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    waitFrameTick(300, "frame after bounds write");
    tFrame = t;
    for (int k = 0; k < 4; k++) begin
      runCycles((k == 0) ? 30 : SLOT);
      checkOutput($sformatf("frame digit %0d after bounds write", k), frameSeg[k],
                  4'(4'b0001 << k), 1'b0);
    end

    $display("[TB] enable gap and async reset");
    applyStimulus(1'b0, 1'b0, 3'd0, 5'h00, 4'd15);
    stepCycle();
    checkOutput("en low dark after one cycle", 8'h00, 4'b0000, 1'b0);
    runCycles(9);
    applyStimulus(1'b1, 1'b0, 3'd0, 5'h00, 4'd15);
    waitFrameTick(300, "frame after en gap");
    checkValue("frame period across en gap", t - tFrame, FRAME);
    runCycles(10);
    checkOutput("driving before mid-slot reset", 8'h60, 4'b0001, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset clears outputs", 8'h00, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    releaseReset();

    $display("[TB] randomized run");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    4'($urandom_range(0, 15)));
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
